// File: rtl/ac_actuator.sv
// AC actuator: ramped fan speed with PWM drive, and a compressor controller
// that enforces minimum run and lockout times with a fan-loss override.
module ac_actuator #(
    parameter int PWM_PERIOD  = 16,
    parameter int RAMP_CYCLES = 8,
    parameter int MIN_ON      = 16,
    parameter int MIN_OFF     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] fan_speed_cmd,
    input  logic [7:0] fan_heat_cmd,
    input  logic [6:0] coil_temp,
    output logic       fan_pwm,
    output logic [2:0] fan_speed_act,
    output logic       compressor_on,
    output logic       cmd_error,
    output logic [1:0] comp_state
);

    localparam int PW       = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int DW       = $clog2(PWM_PERIOD + 1);
    localparam int RW       = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int CMAX     = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int CW       = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int DUTY_STEP = PWM_PERIOD / 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_LOCKOUT = 2'b10,
        ST_BAD     = 2'b11
    } comp_state_t;

    logic [2:0]  speed_cmd_q, speed_cmd_d;
    logic [7:0]  heat_cmd_q, heat_cmd_d;
    logic [6:0]  coil_q, coil_d;
    logic        cmd_error_q, cmd_error_d;
    logic [2:0]  fan_speed_act_q, fan_speed_act_d;
    logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic        fan_pwm_q, fan_pwm_d;
    comp_state_t state_q, state_d;
    logic [CW-1:0] state_cnt_q, state_cnt_d;
    logic        compressor_on_q, compressor_on_d;

    logic [2:0]  speed_target;
    logic [6:0]  heat_target;
    logic        demand;
    logic        pwm_wrap;

    always_comb begin
        speed_cmd_d  = fan_speed_cmd;
        heat_cmd_d   = fan_heat_cmd;
        coil_d       = coil_temp;
        speed_target = (speed_cmd_q > 3'd4) ? 3'd4 : speed_cmd_q;
        heat_target  = (heat_cmd_q > 8'd127) ? 7'd0 : heat_cmd_q[6:0];
        cmd_error_d  = (speed_cmd_q > 3'd4) || (heat_cmd_q > 8'd127);
    end

    // The ramp counter keeps running across target changes; only the direction follows the target.
    always_comb begin
        ramp_cnt_d      = ramp_cnt_q;
        fan_speed_act_d = fan_speed_act_q;
        if (fan_speed_act_q == speed_target) begin
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RW'(RAMP_CYCLES - 1)) begin
            ramp_cnt_d = '0;
            if (fan_speed_act_q < speed_target) begin
                fan_speed_act_d = fan_speed_act_q + 3'd1;
            end else begin
                fan_speed_act_d = fan_speed_act_q - 3'd1;
            end
        end else begin
            ramp_cnt_d = ramp_cnt_q + RW'(1);
        end
    end

    // Duty only reloads at the period boundary so a full-on period never glitches low.
    always_comb begin
        pwm_wrap  = (pwm_cnt_q == PW'(PWM_PERIOD - 1));
        pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + PW'(1);
        duty_d    = duty_q;
        if (pwm_wrap) begin
            duty_d = DW'(fan_speed_act_q) * DW'(DUTY_STEP);
        end
        fan_pwm_d = (DW'(pwm_cnt_q) < duty_q);
    end

    always_comb begin
        demand = (fan_speed_act_q != 3'd0) && (heat_target != 7'd0) &&
                 (coil_q > heat_target);
    end

    always_comb begin
        state_d     = state_q;
        state_cnt_d = state_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (demand) begin
                    state_d     = ST_RUN;
                    state_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (fan_speed_act_q == 3'd0) begin
                    state_d     = ST_LOCKOUT;
                    state_cnt_d = '0;
                end else if (!demand && (state_cnt_q == CW'(MIN_ON - 1))) begin
                    state_d     = ST_LOCKOUT;
                    state_cnt_d = '0;
                end else if (state_cnt_q != CW'(MIN_ON - 1)) begin
                    state_cnt_d = state_cnt_q + CW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (state_cnt_q == CW'(MIN_OFF - 1)) begin
                    state_d     = ST_IDLE;
                    state_cnt_d = '0;
                end else begin
                    state_cnt_d = state_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = ST_LOCKOUT;
                state_cnt_d = '0;
            end
        endcase
        compressor_on_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_cmd_q     <= '0;
            heat_cmd_q      <= '0;
            coil_q          <= '0;
            cmd_error_q     <= 1'b0;
            fan_speed_act_q <= '0;
            ramp_cnt_q      <= '0;
            pwm_cnt_q       <= '0;
            duty_q          <= '0;
            fan_pwm_q       <= 1'b0;
            state_q         <= ST_IDLE;
            state_cnt_q     <= '0;
            compressor_on_q <= 1'b0;
        end else begin
            speed_cmd_q     <= speed_cmd_d;
            heat_cmd_q      <= heat_cmd_d;
            coil_q          <= coil_d;
            cmd_error_q     <= cmd_error_d;
            fan_speed_act_q <= fan_speed_act_d;
            ramp_cnt_q      <= ramp_cnt_d;
            pwm_cnt_q       <= pwm_cnt_d;
            duty_q          <= duty_d;
            fan_pwm_q       <= fan_pwm_d;
            state_q         <= state_d;
            state_cnt_q     <= state_cnt_d;
            compressor_on_q <= compressor_on_d;
        end
    end

    assign fan_pwm       = fan_pwm_q;
    assign fan_speed_act = fan_speed_act_q;
    assign compressor_on = compressor_on_q;
    assign cmd_error     = cmd_error_q;
    assign comp_state    = state_q;

endmodule

// File: tb/tb_ac_actuator.sv
// Directed bench for ac_actuator: ramp timing, PWM duty, compressor
// minimum times, fan-loss safety, invalid commands and mid-run reset.
module tb_ac_actuator;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] fan_speed_cmd;
    logic [7:0] fan_heat_cmd;
    logic [6:0] coil_temp;
    logic       fan_pwm;
    logic [2:0] fan_speed_act;
    logic       compressor_on;
    logic       cmd_error;
    logic [1:0] comp_state;

    int total_checks = 0;
    int bad_checks   = 0;
    int highs;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] RUN     = 2'b01;
    localparam logic [1:0] LOCKOUT = 2'b10;

    ac_actuator #(
        .PWM_PERIOD (16),
        .RAMP_CYCLES(8),
        .MIN_ON     (16),
        .MIN_OFF    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fan_speed_cmd(fan_speed_cmd),
        .fan_heat_cmd (fan_heat_cmd),
        .coil_temp    (coil_temp),
        .fan_pwm      (fan_pwm),
        .fan_speed_act(fan_speed_act),
        .compressor_on(compressor_on),
        .cmd_error    (cmd_error),
        .comp_state   (comp_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] speed, input logic [7:0] heat,
                                 input logic [6:0] coil);
        fan_speed_cmd = speed;
        fan_heat_cmd  = heat;
        coil_temp     = coil;
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic countPwmHigh(input int n, output int count);
        count = 0;
        for (int i = 0; i < n; i++) begin
            waitEdges(1);
            if (fan_pwm === 1'b1) count++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(3'd0, 8'd0, 7'd0);
        #12;
        checkOutput("rst_pwm", fan_pwm, 0);
        checkOutput("rst_act", fan_speed_act, 0);
        checkOutput("rst_comp", compressor_on, 0);
        checkOutput("rst_err", cmd_error, 0);
        checkOutput("rst_state", comp_state, IDLE);
        @(posedge clk);
        #1 reset = 1'b1;
        waitEdges(3);

        // Ramp 0 -> 3: steps land 9, 17 and 25 edges after the command change.
        applyStimulus(3'd3, 8'd0, 7'd0);
        waitEdges(8);
        checkOutput("ramp_e8", fan_speed_act, 0);
        waitEdges(1);
        checkOutput("ramp_e9", fan_speed_act, 1);
        waitEdges(7);
        checkOutput("ramp_e16", fan_speed_act, 1);
        waitEdges(1);
        checkOutput("ramp_e17", fan_speed_act, 2);
        waitEdges(8);
        checkOutput("ramp_e25", fan_speed_act, 3);
        waitEdges(10);
        checkOutput("ramp_hold", fan_speed_act, 3);

        applyStimulus(3'd2, 8'd0, 7'd0);
        waitEdges(9);
        checkOutput("down_e9", fan_speed_act, 2);
        waitEdges(40);
        countPwmHigh(16, highs);
        checkOutput("pwm_spd2", highs, 8);

        applyStimulus(3'd4, 8'd0, 7'd0);
        waitEdges(17);
        checkOutput("up4_e17", fan_speed_act, 4);
        waitEdges(40);
        countPwmHigh(32, highs);
        checkOutput("pwm_spd4", highs, 32);

        applyStimulus(3'd0, 8'd0, 7'd0);
        waitEdges(33);
        checkOutput("down0_e33", fan_speed_act, 0);
        waitEdges(40);
        countPwmHigh(32, highs);
        checkOutput("pwm_spd0", highs, 0);
        checkOutput("err_valid", cmd_error, 0);

        // Out-of-range speed saturates to 4; out-of-range heat suppresses demand.
        applyStimulus(3'd6, 8'd0, 7'd0);
        waitEdges(1);
        checkOutput("err_lat1", cmd_error, 0);
        waitEdges(1);
        checkOutput("err_spd6", cmd_error, 1);
        waitEdges(31);
        checkOutput("spd6_act", fan_speed_act, 4);
        waitEdges(10);
        checkOutput("spd6_sat", fan_speed_act, 4);
        applyStimulus(3'd2, 8'd200, 7'd127);
        waitEdges(2);
        checkOutput("err_heat", cmd_error, 1);
        waitEdges(28);
        checkOutput("heat_act", fan_speed_act, 2);
        checkOutput("heat_nodem", comp_state, IDLE);
        checkOutput("heat_comp", compressor_on, 0);

        // Minimum run time, then lockout.
        applyStimulus(3'd2, 8'd20, 7'd30);
        waitEdges(1);
        checkOutput("cmp_e1", comp_state, IDLE);
        waitEdges(1);
        checkOutput("cmp_e2", comp_state, RUN);
        checkOutput("cmp_on_e2", compressor_on, 1);
        checkOutput("cmp_err_e2", cmd_error, 0);
        waitEdges(2);
        applyStimulus(3'd2, 8'd20, 7'd15);
        waitEdges(13);
        checkOutput("cmp_e17", comp_state, RUN);
        checkOutput("cmp_on_e17", compressor_on, 1);
        waitEdges(1);
        checkOutput("cmp_e18", comp_state, LOCKOUT);
        checkOutput("cmp_on_e18", compressor_on, 0);
        waitEdges(31);
        checkOutput("cmp_e49", comp_state, LOCKOUT);
        waitEdges(1);
        checkOutput("cmp_e50", comp_state, IDLE);
        waitEdges(5);
        checkOutput("cmp_e55", comp_state, IDLE);

        applyStimulus(3'd1, 8'd20, 7'd15);
        waitEdges(12);
        checkOutput("spd1_act", fan_speed_act, 1);

        // Fan loss forces lockout early; demand during lockout is ignored until exit.
        applyStimulus(3'd1, 8'd20, 7'd30);
        waitEdges(2);
        checkOutput("loss_run", comp_state, RUN);
        applyStimulus(3'd0, 8'd20, 7'd30);
        waitEdges(9);
        checkOutput("loss_act0", fan_speed_act, 0);
        checkOutput("loss_e11", comp_state, RUN);
        waitEdges(1);
        checkOutput("loss_e12", comp_state, LOCKOUT);
        checkOutput("loss_on", compressor_on, 0);
        applyStimulus(3'd1, 8'd20, 7'd30);
        waitEdges(18);
        checkOutput("lock_act1", fan_speed_act, 1);
        checkOutput("lock_ign", comp_state, LOCKOUT);
        waitEdges(13);
        checkOutput("lock_e43", comp_state, LOCKOUT);
        waitEdges(1);
        checkOutput("lock_e44", comp_state, IDLE);
        waitEdges(1);
        checkOutput("rerun_e45", comp_state, RUN);

        applyStimulus(3'd3, 8'd20, 7'd30);
        waitEdges(30);
        checkOutput("pre_rst_act", fan_speed_act, 3);
        checkOutput("pre_rst_on", compressor_on, 1);
        #3 reset = 1'b0;
        #1;
        checkOutput("arst_pwm", fan_pwm, 0);
        checkOutput("arst_act", fan_speed_act, 0);
        checkOutput("arst_on", compressor_on, 0);
        checkOutput("arst_err", cmd_error, 0);
        checkOutput("arst_state", comp_state, IDLE);
        waitEdges(2);
        checkOutput("hold_state", comp_state, IDLE);
        reset = 1'b1;
        waitEdges(1);
        checkOutput("rel_e1_st", comp_state, IDLE);
        checkOutput("rel_e1_act", fan_speed_act, 0);
        waitEdges(1);
        checkOutput("rel_e2_st", comp_state, IDLE);
        waitEdges(7);
        checkOutput("rel_e9_act", fan_speed_act, 1);
        checkOutput("rel_e9_st", comp_state, IDLE);
        waitEdges(1);
        checkOutput("rel_e10_st", comp_state, RUN);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/ac_actuator.md
AC_ACTUATOR -- requirements
Module: ac_actuator

Interface
REQ-001 The block SHALL have parameter PWM_PERIOD, default 16, fan PWM period in clk cycles; a multiple of 4 and at least 4.
REQ-002 The block SHALL have parameter RAMP_CYCLES, default 8, clk cycles per one-step change of the actual fan speed.
REQ-003 The block SHALL have parameter MIN_ON, default 16, minimum compressor run time in cycles.
REQ-004 The block SHALL have parameter MIN_OFF, default 32, compressor lockout time in cycles after stopping.
REQ-005 The block SHALL have ports:
  clk  in  1  clock, rising edge.
  reset  in  1  asynchronous, active-low.
  fan_speed_cmd  in  3  commanded fan speed; valid range 0..4.
  fan_heat_cmd  in  8  commanded coil temperature; valid range 0..127.
  coil_temp  in  7  measured coil temperature.
  fan_pwm  out  1  fan motor PWM drive.
  fan_speed_act  out  3  current ramped fan speed, 0..4.
  compressor_on  out  1  compressor enable.
  cmd_error  out  1  high while a registered command is out of range.
  comp_state  out  2  compressor FSM state: 00 IDLE, 01 RUN, 10 LOCKOUT.

Function
REQ-006 All inputs SHALL be registered once; all decisions SHALL use only these registered values, giving 1 cycle of input latency.
REQ-007 The speed target SHALL be min(registered fan_speed_cmd, 4).
REQ-008 The heat target SHALL be the registered fan_heat_cmd when it is 127 or less, and 0 otherwise.
REQ-009 cmd_error SHALL be registered and high exactly when the registered fan_speed_cmd > 4 or registered fan_heat_cmd > 127.
REQ-010 Fan ramp:
  - When fan_speed_act equals the speed target, the ramp counter SHALL hold at 0.
  - Otherwise the ramp counter SHALL increment every cycle.
  - When the counter reaches RAMP_CYCLES-1, fan_speed_act SHALL step by 1 toward the target and the counter SHALL return to 0.
REQ-011 A change of speed target during a ramp SHALL NOT reset the ramp counter; the step direction SHALL follow the new target.
REQ-012 PWM:
  - A counter SHALL run free 0..PWM_PERIOD-1 and then wrap.
  - A duty register SHALL load fan_speed_act*(PWM_PERIOD/4) only in the cycle where the counter equals PWM_PERIOD-1.
  - fan_pwm SHALL be registered and equal (counter < duty).
REQ-013 Duty 0 SHALL give constant fan_pwm=0; speed 4 SHALL give constant fan_pwm=1 with no glitch at the period wrap.
REQ-014 demand SHALL be (fan_speed_act != 0) AND (heat target != 0) AND (registered coil_temp > heat target).
REQ-015 From IDLE the FSM SHALL move to RUN on demand, and clear the run counter on entry.
REQ-016 In RUN the run counter SHALL increment and saturate at MIN_ON-1.
REQ-017 From RUN the FSM SHALL move to LOCKOUT when demand is low AND the run counter equals MIN_ON-1.
REQ-018 From RUN the FSM SHALL move to LOCKOUT immediately when fan_speed_act == 0, overriding MIN_ON (safety).
REQ-019 In LOCKOUT the FSM SHALL count MIN_OFF cycles, then return to IDLE, ignoring demand.
REQ-020 If demand is present at LOCKOUT exit, the FSM SHALL re-enter RUN on the next evaluation from IDLE.
REQ-021 compressor_on SHALL be registered and high only in RUN; comp_state SHALL reflect the current state.
REQ-022 Unused state encoding 11 SHALL recover to LOCKOUT with its counter cleared.

Reset
REQ-023 While reset is low, all outputs SHALL be 0: fan_pwm, fan_speed_act, compressor_on, cmd_error, comp_state=IDLE.
REQ-024 While reset is low, all counters and input registers SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL force the compressor off at once, with no LOCKOUT period.
REQ-026 After reset release, the first state change SHALL be no earlier than the second rising edge.

Verification
REQ-027 Speed ramp: cmd 0->3, defaults -> fan_speed_act reads 1, 2, 3 at 8-cycle spacing; first step 9 cycles after the input change.
REQ-028 PWM duty: speed 2 settled -> fan_pwm high 8 of every 16 cycles; speed 4 -> never low; speed 0 -> never high.
REQ-029 Compressor minimum times: speed 2, heat 20, coil 30 -> RUN; coil drops to 15 after 3 cycles -> compressor stays on until 16 RUN cycles, then LOCKOUT for 32 cycles, then IDLE.
REQ-030 Fan-loss safety: in RUN, speed cmd 0 -> LOCKOUT when fan_speed_act reaches 0, even with fewer than 16 RUN cycles.
REQ-031 Invalid commands: speed cmd 6 -> cmd_error=1 and target 4; heat cmd 200 -> cmd_error=1 and no demand.
REQ-032 Mid-operation reset: reset pulse during RUN at speed 3 -> all outputs 0 asynchronously; restart from IDLE with speed 0.
